tq_tran_buf: RTL
================

# tq_tran_buf

Transpose buffer for the 2-D DCT/IDCT in rec_tq: accepts one row of up to 32 first-pass coefficients per cycle and, once a full N×N block is held, emits it column by column for the second pass. Storage is 32 single-port banks with diagonal (skewed) placement, so every row write and every column read touches each bank exactly once. This is the data end of the bank-address/lane-rotation scheme: it owns its own address generation and both rotation networks.

## Interface
- DW, 16, coefficient width in bits
- clk  input  1  clock; all logic on the rising edge
- rst_n  input  1  synchronous active-low reset, sampled on clk
- i_valid  input  1  row strobe; accepted only when o_ready=1
- i_transize  input  2  block size: 0=4×4, 1=8×8, 2=16×16, 3=32×32; sampled on the first row of a block
- i_data  input  32*DW  row; lane k at bits [k*DW +: DW], lanes 0..N-1 used
- o_ready  output  1  buffer is in write phase and accepts rows
- o_valid  output  1  o_data holds a column
- o_data  output  32*DW  column; lane r = element (row r, column c)
- o_last  output  1  with o_valid, marks column N-1
- o_transize  output  2  latched size of the block being read

## Operation
- N = 4 << i_transize. Size latched into sz_r when a row is accepted with row counter = 0; i_transize changes mid-block are ignored.
- States: WR (reset state) and RD. In WR, o_ready=1; each accepted row (i_valid & o_ready) increments row counter r. On the N-th row, r wraps to 0 and state goes to RD.
- Write mapping, row r: input lane k goes to bank (k+r) mod N at address r; a lane rotator shifts i_data left by r within the N-lane window. Lanes ≥ N are not written. Modulo is taken in N, not 32.
- RD: column counter c runs 0..N-1, one read per cycle, unconditionally (no output back-pressure). Bank b reads address (b−c) mod N. Read data is rotated so that output lane r takes bank (c+r) mod N. Output lanes ≥ N are driven 0.
- After the read with c=N-1 is issued, c wraps to 0 and state returns to WR.
- i_valid while o_ready=0 is ignored; that row is dropped and no state changes.
- Reset mid-block: the block is discarded, state goes to WR, and counters go to 0. Bank contents are don't-care.

## Timing
- Reset values: o_ready=1, o_valid=0, o_last=0, o_data=0, o_transize=0, r=0, c=0.
- Banks have a 1-cycle registered read. A column read is issued at cycle t and appears on o_data with o_valid=1 at t+1. The output rotator is combinational after the bank register, or it is registered with the whole path kept at 1 cycle.
- Last row accepted at cycle T → state RD at T+1 (read column 0 issued) → column 0 valid at T+2 → column N-1 valid with o_last=1 at T+N+1.
- o_ready is 0 during cycles T+1..T+N and returns to 1 at T+N+1, the same cycle as the last column. A new row accepted then does not corrupt the column being output.
- Steady-state period is 2N cycles per block: N write cycles and N read cycles.
- o_transize is valid with o_valid and holds until the next block's first read.
- o_valid is a single-cycle pulse per column; it stays 0 whenever no read was issued in the previous cycle.

## Test plan
- 4×4 transpose: i_transize=0, rows with element(r,k)=16r+k sent on consecutive cycles. Expect o_ready low for 4 cycles, columns at T+2..T+5 with lane r of column c = 16r+c, o_last at T+5, lanes 4..31 = 0.
- 32×32 transpose, back-to-back blocks: value(r,k)=32r+k, and the second block starts on the cycle o_ready rises. Expect both blocks transposed exactly, period 64 cycles, and no dropped or duplicated column.
- Mixed sizes: an 8×8 block followed by a 16×16 block, with i_transize toggled randomly after the first row of each block. Expect o_transize=1 then 2, and correct transposes using the latched size.
- Ignored writes: assert i_valid with pattern 0xDEAD on every cycle of RD. Expect no effect on output columns and no effect on the next block.
- Gapped input: 8×8 rows with random i_valid gaps of 0–3 cycles. Expect the output identical to the gapless case, and columns contiguous on 8 consecutive cycles.
- Reset mid-operation: pull rst_n low for 1 cycle after row 5 of a 16×16 block. Next cycle expect o_ready=1 and o_valid=0. A fresh 4×4 block then transposes correctly with no stale data.

Source files
------------

// File: rtl/tq_tran_buf.sv
// rtl/tq_tran_buf.sv - transpose buffer for the 2-D DCT/IDCT second pass
// Rows are written diagonally across 32 banks so each row write and each column read hits every bank once.
module tq_tran_buf #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [1:0]      i_transize,
  input  logic [32*DW-1:0] i_data,
  output logic            o_ready,
  output logic            o_valid,
  output logic [32*DW-1:0] o_data,
  output logic            o_last,
  output logic [1:0]      o_transize
);

  localparam int NB = 32;

  typedef enum logic {ST_WR, ST_RD} state_t;

  state_t      state;
  logic [4:0]  row;
  logic [4:0]  col;
  logic [4:0]  col_q;
  logic [1:0]  sz_r;
  logic [1:0]  sz_q;
  logic        ready_r;
  logic        valid_q;
  logic        last_q;
  logic        accept;
  logic [1:0]  cur_sz;
  logic [4:0]  cur_mask;
  logic [4:0]  sz_mask;
  logic [4:0]  out_mask;
  logic [DW-1:0] rd_q [NB];

  // N-1 for a block of size code s; all bank/lane arithmetic is modulo N via this mask.
  function automatic logic [4:0] mask_of(input logic [1:0] s);
    return 5'((6'd4 << s) - 6'd1);
  endfunction

  assign accept   = i_valid & ready_r;
  assign cur_sz   = (row == 5'd0) ? i_transize : sz_r;
  assign cur_mask = mask_of(cur_sz);
  assign sz_mask  = mask_of(sz_r);
  assign out_mask = mask_of(sz_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_WR;
      ready_r <= 1'b1;
      row     <= 5'd0;
      col     <= 5'd0;
      col_q   <= 5'd0;
      sz_r    <= 2'd0;
      sz_q    <= 2'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      case (state)
        ST_WR: begin
          if (accept) begin
            if (row == 5'd0) sz_r <= i_transize;
            if (row == cur_mask) begin
              row     <= 5'd0;
              state   <= ST_RD;
              ready_r <= 1'b0;
            end else begin
              row <= row + 5'd1;
            end
          end
        end
        ST_RD: begin
          valid_q <= 1'b1;
          col_q   <= col;
          sz_q    <= sz_r;
          last_q  <= (col == sz_mask);
          if (col == sz_mask) begin
            col     <= 5'd0;
            state   <= ST_WR;
            ready_r <= 1'b1;
          end else begin
            col <= col + 5'd1;
          end
        end
        default: begin
          state   <= ST_WR;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    localparam logic [4:0] BI = 5'(b);
    logic [DW-1:0] mem [NB];
    logic [DW-1:0] q;
    logic [4:0]    src;
    logic [4:0]    rd_addr;
    logic [4:0]    addr;
    logic          we;

    // Bank b holds lane (b-r) of row r at address r; column c lives at address (b-c).
    assign src     = (BI - row) & cur_mask;
    assign rd_addr = (BI - col) & sz_mask;
    assign we      = accept && (BI <= cur_mask);
    assign addr    = we ? row : rd_addr;

    always_ff @(posedge clk) begin
      if (we) begin
        mem[addr] <= i_data[src*DW +: DW];
      end else if (state == ST_RD) begin
        q <= mem[addr];
      end
    end

    assign rd_q[b] = q;
  end

  // Output lane l of column c comes from bank (c+l) mod N.
  always_comb begin
    o_data = '0;
    if (valid_q) begin
      for (int l = 0; l < NB; l++) begin
        if (5'(l) <= out_mask) begin
          o_data[l*DW +: DW] = rd_q[(col_q + 5'(l)) & out_mask];
        end
      end
    end
  end

  assign o_ready    = ready_r;
  assign o_valid    = valid_q;
  assign o_last     = last_q;
  assign o_transize = sz_q;

endmodule
